id_stage_hazard: RTL
====================

// Module: id_stage_hazard
// PURPOSE
//  Registered instruction-decode stage: decodes a MIPS32 word, reads two GPR operands with forwarding, and registers the ID/EX payload.
//  Generalises the combinational decoder: any number of forwarding sources, $0 hardwired, load-use stall detection and a valid/ready ID/EX handshake.
//  Adds flush, illegal-instruction flagging and a saturating stall counter. Sits between IF/ID and EX.
// PARAMETERS
//  DATA_W   32  operand/result width
//  RADDR_W  5   GPR address width
//  NUM_FWD  2   forwarding sources, index 0 = youngest (EX), NUM_FWD-1 = oldest
//  CNT_W    16  stall counter width
// PORTS
//  clk          in   1                clock
//  rst          in   1                reset: rst, synchronous, active-high
//  flush_i      in   1                discard ID instruction and ID/EX payload
//  id_valid_i   in   1                inst_i/pc_i valid
//  id_ready_o   out  1                ID accepts instruction this cycle
//  pc_i         in   32               instruction address
//  inst_i       in   32               instruction word
//  rf_raddr1_o  out  RADDR_W          GPR read address 1 (rs)
//  rf_raddr2_o  out  RADDR_W          GPR read address 2 (rt)
//  rf_rdata1_i  in   DATA_W           GPR read data 1, same cycle
//  rf_rdata2_i  in   DATA_W           GPR read data 2, same cycle
//  fwd_wreg_i   in   NUM_FWD          source k writes a GPR
//  fwd_wd_i     in   NUM_FWD*RADDR_W  source k destination, packed k*RADDR_W
//  fwd_wdata_i  in   NUM_FWD*DATA_W   source k result, packed
//  fwd_pend_i   in   NUM_FWD          source k result not yet available (load)
//  ex_valid_o   out  1                ID/EX payload valid
//  ex_ready_i   in   1                EX accepts payload
//  ex_pc_o      out  32               registered pc
//  ex_aluop_o   out  ALUOP_W          registered ALU op
//  ex_alusel_o  out  ALUSEL_W         registered result select
//  ex_reg1_o    out  DATA_W           registered operand 1
//  ex_reg2_o    out  DATA_W           registered operand 2
//  ex_wd_o      out  RADDR_W          registered destination
//  ex_wreg_o    out  1                registered write enable
//  ex_illegal_o out  1                registered illegal-instruction flag
//  stall_cnt_o  out  CNT_W            saturating count of hazard-stall cycles
// BEHAVIOUR
//  - Reset: all ex_* outputs 0 (NOP op/sel), ex_valid_o=0, stall_cnt_o=0, state RUN.
//  - Decode: OR/AND/XOR/NOR/SLLV/SRLV/SRAV/SYNC (SPECIAL, sa=0).
//    SLL/SRL/SRA (inst[31:21]=0, shamt -> reg1 as zero-extended imm).
//    ORI/ANDI/XORI (zero-ext imm, wd=rt), LUI ({imm,16'h0}, rs read), PREF (NOP).
//    Anything else: NOP payload, wreg=0, ex_illegal_o=1.
//  - Unused operand port = decoded immediate (0 if none).
//  - Operand select per port, priority: no read -> imm; addr==0 -> 0 (never forwarded);
//    lowest k with wreg&&wd==addr -> fwd_wdata[k]; else rf_rdata.
//  - Hazard: the selected matching source k has fwd_pend_i[k]=1. Only the highest-priority match counts.
//  - FSM RUN: hazard&&id_valid_i -> STALL; id_ready_o=0; bubble (ex_valid_o=0) issued when EX slot free.
//  - FSM STALL: id_ready_o=0 while hazard persists; hazard clear -> RUN, instruction issues that cycle.
//  - stall_cnt_o increments each cycle in STALL or RUN-with-hazard; saturates at all-ones.
//  - Handshake: ID/EX loads when !ex_valid_o||ex_ready_i.
//    id_ready_o = load && !hazard && !flush_i. Payload held stable while ex_valid_o&&!ex_ready_i.
//  - Latency: accepted instruction appears on ex_* next cycle. Full throughput 1/cycle.
//  - flush_i: next cycle ex_valid_o=0, state RUN, no instruction accepted; dominates hazard and handshake. Counter unchanged.
//  - rst mid-stall: returns to RUN, counter cleared.
// STRUCTURE
//  - Shared package: opcode/func constants, ALUOP_W=8, ALUSEL_W=3, aluop/alusel codes, NOP payload constant.
//  - Sub-module id_decode_core: combinational inst -> aluop/alusel/wd/wreg/read enables/imm/illegal.
//  - Top holds forwarding mux (generate over NUM_FWD), hazard FSM, ID/EX register, counter.
// TESTING
//  - ORI $1,$0,0x1100 then OR $2,$1,$1 with fwd0 wd=1 data=0x1100 -> ex_reg1=ex_reg2=0x1100, wd=2.
//  - fwd0 and fwd1 both wd=3 (0xAA, 0xBB), ADDR read $3 -> operand 0xAA; wd=0 with wreg -> operand 0.
//  - fwd0 wd=4 pend=1, OR $5,$4,$4 -> id_ready_o=0, one bubble, stall_cnt_o=1. Pend drops -> issues next cycle.
//  - ex_ready_i=0 for 3 cycles after a valid payload -> ex_* stable, id_ready_o=0. Release -> next instruction 1 cycle later.
//  - Opcode 6'h3F -> ex_illegal_o=1, ex_wreg_o=0. SLL $6,$7,5 -> reg1=5, aluop SLL.
//  - flush_i during STALL -> ex_valid_o=0, state RUN. Hold hazard 2^CNT_W+2 cycles (CNT_W=4) -> stall_cnt_o=15.

Source files
------------

// File: rtl/id_stage_hazard_pkg.sv
// Shared decode constants for the ID stage: MIPS opcode/function fields,
// ALU operation and result-select codes, and the hazard FSM state type.
package id_stage_hazard_pkg;

  localparam int ALUOP_W  = 8;
  localparam int ALUSEL_W = 3;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_PREF    = 6'h33;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_SYNC = 6'h0F;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;

  localparam logic [ALUOP_W-1:0] AOP_NOP = 8'h00;
  localparam logic [ALUOP_W-1:0] AOP_AND = 8'h24;
  localparam logic [ALUOP_W-1:0] AOP_OR  = 8'h25;
  localparam logic [ALUOP_W-1:0] AOP_XOR = 8'h26;
  localparam logic [ALUOP_W-1:0] AOP_NOR = 8'h27;
  localparam logic [ALUOP_W-1:0] AOP_SLL = 8'h7C;
  localparam logic [ALUOP_W-1:0] AOP_SRL = 8'h02;
  localparam logic [ALUOP_W-1:0] AOP_SRA = 8'h03;

  localparam logic [ALUSEL_W-1:0] SEL_NOP   = 3'd0;
  localparam logic [ALUSEL_W-1:0] SEL_LOGIC = 3'd1;
  localparam logic [ALUSEL_W-1:0] SEL_SHIFT = 3'd2;

  typedef enum logic {ST_RUN, ST_STALL} hz_state_t;

endpackage

// File: rtl/id_stage_hazard_if.sv
// ID/EX payload channel with valid/ready handshake.
interface id_stage_hazard_if import id_stage_hazard_pkg::*; #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) ();
  logic                ex_valid;
  logic                ex_ready;
  logic [31:0]         ex_pc;
  logic [ALUOP_W-1:0]  ex_aluop;
  logic [ALUSEL_W-1:0] ex_alusel;
  logic [DATA_W-1:0]   ex_reg1;
  logic [DATA_W-1:0]   ex_reg2;
  logic [RADDR_W-1:0]  ex_wd;
  logic                ex_wreg;
  logic                ex_illegal;

  modport master (
    output ex_valid, ex_pc, ex_aluop, ex_alusel, ex_reg1, ex_reg2,
           ex_wd, ex_wreg, ex_illegal,
    input  ex_ready
  );
  modport slave (
    input  ex_valid, ex_pc, ex_aluop, ex_alusel, ex_reg1, ex_reg2,
           ex_wd, ex_wreg, ex_illegal,
    output ex_ready
  );
endinterface

// File: rtl/id_stage_hazard_decode_core.sv
// Combinational MIPS32 decoder: instruction word to ALU controls, destination,
// read enables, immediate and illegal flag.
module id_decode_core import id_stage_hazard_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic [31:0]         inst,
  output logic [ALUOP_W-1:0]  aluop,
  output logic [ALUSEL_W-1:0] alusel,
  output logic [4:0]          wd,
  output logic                wreg,
  output logic                re1,
  output logic                re2,
  output logic [DATA_W-1:0]   imm,
  output logic                illegal
);
  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd, sa;

  assign op = inst[31:26];
  assign rs = inst[25:21];
  assign rt = inst[20:16];
  assign rd = inst[15:11];
  assign sa = inst[10:6];
  assign fn = inst[5:0];

  function automatic logic [ALUOP_W-1:0] fn_aluop(input logic [5:0] f);
    case (f)
      FN_OR:           return AOP_OR;
      FN_AND:          return AOP_AND;
      FN_XOR:          return AOP_XOR;
      FN_NOR:          return AOP_NOR;
      FN_SLL, FN_SLLV: return AOP_SLL;
      FN_SRL, FN_SRLV: return AOP_SRL;
      FN_SRA, FN_SRAV: return AOP_SRA;
      default:         return AOP_NOP;
    endcase
  endfunction

  always_comb begin
    aluop   = AOP_NOP;
    alusel  = SEL_NOP;
    wd      = '0;
    wreg    = 1'b0;
    re1     = 1'b0;
    re2     = 1'b0;
    imm     = '0;
    illegal = 1'b1;
    case (op)
      OP_SPECIAL: begin
        case (fn)
          FN_OR, FN_AND, FN_XOR, FN_NOR, FN_SLLV, FN_SRLV, FN_SRAV: begin
            if (sa == 5'd0) begin
              illegal = 1'b0;
              wreg    = 1'b1;
              wd      = rd;
              re1     = 1'b1;
              re2     = 1'b1;
              aluop   = fn_aluop(fn);
              alusel  = fn[5] ? SEL_LOGIC : SEL_SHIFT;
            end
          end
          // Constant shifts carry shamt through operand 1 as an immediate.
          FN_SLL, FN_SRL, FN_SRA: begin
            if (rs == 5'd0) begin
              illegal = 1'b0;
              wreg    = 1'b1;
              wd      = rd;
              re2     = 1'b1;
              imm     = DATA_W'(sa);
              aluop   = fn_aluop(fn);
              alusel  = SEL_SHIFT;
            end
          end
          FN_SYNC: illegal = (sa != 5'd0);
          default: ;
        endcase
      end
      OP_ORI, OP_ANDI, OP_XORI: begin
        illegal = 1'b0;
        wreg    = 1'b1;
        wd      = rt;
        re1     = 1'b1;
        imm     = DATA_W'(inst[15:0]);
        alusel  = SEL_LOGIC;
        aluop   = (op == OP_ORI) ? AOP_OR : ((op == OP_ANDI) ? AOP_AND : AOP_XOR);
      end
      OP_LUI: begin
        illegal = 1'b0;
        wreg    = 1'b1;
        wd      = rt;
        re1     = 1'b1;
        imm     = DATA_W'({inst[15:0], 16'h0});
        alusel  = SEL_LOGIC;
        aluop   = AOP_OR;
      end
      OP_PREF: illegal = 1'b0;
      default: ;
    endcase
  end
endmodule

// File: rtl/id_stage_hazard.sv
// Registered ID stage: decode, operand forwarding, load-use stall FSM and
// the ID/EX pipeline register with valid/ready handshake.
module id_stage_hazard import id_stage_hazard_pkg::*; #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       id_valid_i,
  output logic                       id_ready_o,
  input  logic [31:0]                pc_i,
  input  logic [31:0]                inst_i,
  output logic [RADDR_W-1:0]         rf_raddr1_o,
  output logic [RADDR_W-1:0]         rf_raddr2_o,
  input  logic [DATA_W-1:0]          rf_rdata1_i,
  input  logic [DATA_W-1:0]          rf_rdata2_i,
  input  logic [NUM_FWD-1:0]         fwd_wreg_i,
  input  logic [NUM_FWD*RADDR_W-1:0] fwd_wd_i,
  input  logic [NUM_FWD*DATA_W-1:0]  fwd_wdata_i,
  input  logic [NUM_FWD-1:0]         fwd_pend_i,
  id_stage_hazard_if.master          ex,
  output logic [CNT_W-1:0]           stall_cnt_o
);
  logic [ALUOP_W-1:0]  dec_aluop;
  logic [ALUSEL_W-1:0] dec_alusel;
  logic [4:0]          dec_wd;
  logic                dec_wreg, dec_re1, dec_re2, dec_illegal;
  logic [DATA_W-1:0]   dec_imm;

  id_decode_core #(.DATA_W(DATA_W)) u_dec (
    .inst    (inst_i),
    .aluop   (dec_aluop),
    .alusel  (dec_alusel),
    .wd      (dec_wd),
    .wreg    (dec_wreg),
    .re1     (dec_re1),
    .re2     (dec_re2),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  assign rf_raddr1_o = RADDR_W'(inst_i[25:21]);
  assign rf_raddr2_o = RADDR_W'(inst_i[20:16]);

  logic [DATA_W-1:0] fwd_data [NUM_FWD];
  logic [NUM_FWD-1:0] match1, match2;

  for (genvar k = 0; k < NUM_FWD; k++) begin : g_fwd
    assign fwd_data[k] = fwd_wdata_i[k*DATA_W +: DATA_W];
    assign match1[k]   = fwd_wreg_i[k] && (fwd_wd_i[k*RADDR_W +: RADDR_W] == rf_raddr1_o);
    assign match2[k]   = fwd_wreg_i[k] && (fwd_wd_i[k*RADDR_W +: RADDR_W] == rf_raddr2_o);
  end

  logic [DATA_W-1:0] op1, op2;
  logic              pend1, pend2, found1, found2, hazard;

  // Only the youngest matching source decides both data and pending status.
  always_comb begin
    op1 = rf_rdata1_i;  pend1 = 1'b0;  found1 = 1'b0;
    op2 = rf_rdata2_i;  pend2 = 1'b0;  found2 = 1'b0;
    for (int unsigned k = 0; k < NUM_FWD; k++) begin
      if (match1[k] && !found1) begin
        found1 = 1'b1;  op1 = fwd_data[k];  pend1 = fwd_pend_i[k];
      end
      if (match2[k] && !found2) begin
        found2 = 1'b1;  op2 = fwd_data[k];  pend2 = fwd_pend_i[k];
      end
    end
    if (!dec_re1) begin
      op1 = dec_imm;  pend1 = 1'b0;
    end else if (rf_raddr1_o == '0) begin
      op1 = '0;  pend1 = 1'b0;
    end
    if (!dec_re2) begin
      op2 = dec_imm;  pend2 = 1'b0;
    end else if (rf_raddr2_o == '0) begin
      op2 = '0;  pend2 = 1'b0;
    end
  end

  assign hazard = id_valid_i && (pend1 || pend2);

  hz_state_t state, state_nx;
  logic      load, accept;

  assign load   = !ex.ex_valid || ex.ex_ready;
  assign accept = id_valid_i && id_ready_o;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    id_ready_o = load && !hazard && !flush_i;
    case (state)
      ST_RUN:   if (!flush_i && hazard)  state_nx = ST_STALL;
      ST_STALL: if (flush_i || !hazard)  state_nx = ST_RUN;
      default:  state_nx = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i || (load && !accept)) begin
      ex.ex_valid   <= (rst || flush_i) ? 1'b0 : ex.ex_valid && !load;
      ex.ex_pc      <= '0;
      ex.ex_aluop   <= AOP_NOP;
      ex.ex_alusel  <= SEL_NOP;
      ex.ex_reg1    <= '0;
      ex.ex_reg2    <= '0;
      ex.ex_wd      <= '0;
      ex.ex_wreg    <= 1'b0;
      ex.ex_illegal <= 1'b0;
    end else if (accept) begin
      ex.ex_valid   <= 1'b1;
      ex.ex_pc      <= pc_i;
      ex.ex_aluop   <= dec_aluop;
      ex.ex_alusel  <= dec_alusel;
      ex.ex_reg1    <= op1;
      ex.ex_reg2    <= op2;
      ex.ex_wd      <= RADDR_W'(dec_wd);
      ex.ex_wreg    <= dec_wreg;
      ex.ex_illegal <= dec_illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt_o <= '0;
    else if (hazard && !flush_i && (stall_cnt_o != '1))
      stall_cnt_o <= stall_cnt_o + 1'b1;
  end
endmodule
